// File: rtl/logic_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logic_alu_pkg
// Description : Shared opcode enumeration and default sizing for logic_alu.
// Revision    : 1.0 - initial release
// ============================================================================
package logic_alu_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 16;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_NAND  = 3'd2,
        OP_NOR   = 3'd3,
        OP_XOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_NOT_A = 3'd6,
        OP_PASS_A = 3'd7
    } op_e;

endpackage
`default_nettype wire

// File: rtl/logic_alu_if.sv
`default_nettype none
// ============================================================================
// Module      : logic_alu_if
// Description : Valid/ready operand and result bus of logic_alu.
// Revision    : 1.0 - initial release
// ============================================================================
interface logic_alu_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             acc_sel;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             parity;
    logic [CNT_W-1:0] op_count;

    modport master (
        output in_valid, op, a, b, acc_sel, acc_clr, out_ready,
        input  in_ready, out_valid, y, zero, parity, op_count
    );

    modport slave (
        input  in_valid, op, a, b, acc_sel, acc_clr, out_ready,
        output in_ready, out_valid, y, zero, parity, op_count
    );
endinterface
`default_nettype wire

// File: rtl/logic_op_core.sv
`default_nettype none
// ============================================================================
// Module      : logic_op_core
// Description : Combinational bitwise operator, (op, a, b) -> result.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_op_core
    import logic_alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic [2:0]       op,
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    output logic      [WIDTH-1:0] result
);

    always_comb begin
        result = a;
        case (op_e'(op))
            OP_AND:    result = a & b;
            OP_OR:     result = a | b;
            OP_NAND:   result = ~(a & b);
            OP_NOR:    result = ~(a | b);
            OP_XOR:    result = a ^ b;
            OP_XNOR:   result = ~(a ^ b);
            OP_NOT_A:  result = ~a;
            OP_PASS_A: result = a;
            default:   result = a;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/logic_alu.sv
`default_nettype none
// ============================================================================
// Module      : logic_alu
// Description : One-entry pipelined bitwise ALU with accumulator and op counter.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_alu
    import logic_alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input wire logic  clk,
    input wire logic  rst,
    logic_alu_if.slave bus
);

    logic [WIDTH-1:0] r_y;
    logic             r_zero;
    logic             r_parity;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_op_count;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_xfer;
    logic [WIDTH-1:0] w_operand_b;
    logic [WIDTH-1:0] w_result;

    // A consumer taking the current result frees the slot in the same cycle.
    assign w_in_ready  = !r_out_valid || bus.out_ready;
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_xfer      = r_out_valid && bus.out_ready;
    assign w_operand_b = bus.acc_sel ? r_acc : bus.b;

    logic_op_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op     (bus.op),
        .a      (bus.a),
        .b      (w_operand_b),
        .result (w_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y         <= '0;
            r_zero      <= 1'b1;
            r_parity    <= 1'b0;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_op_count  <= '0;
        end else begin
            if (w_accept) begin
                r_y         <= w_result;
                r_zero      <= ~|w_result;
                r_parity    <= ^w_result;
                r_out_valid <= 1'b1;
                r_acc       <= w_result;
                r_op_count  <= r_op_count + 1'b1;
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
            end
            // Clear wins over the accept's load; the beat itself already saw the old acc.
            if (bus.acc_clr) begin
                r_acc <= '0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.y         = r_y;
    assign bus.zero      = r_zero;
    assign bus.parity    = r_parity;
    assign bus.op_count  = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_logic_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_alu
// Description : Scoreboard testbench for logic_alu (WIDTH=8, plus a CNT_W=4 copy).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_alu;

    logic clk;
    logic rst;

    logic_alu_if #(.WIDTH(8), .CNT_W(16)) bus ();
    logic_alu_if #(.WIDTH(8), .CNT_W(4))  bus4 ();

    logic_alu #(.WIDTH(8), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic_alu #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    int checks = 0;
    int errors = 0;

    logic [9:0]  sb[$];     // {y, zero, parity}
    logic [7:0]  m_acc;
    logic        m_valid;
    logic [15:0] m_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
        case (o)
            3'd0:    return x & z;
            3'd1:    return x | z;
            3'd2:    return ~(x & z);
            3'd3:    return ~(x | z);
            3'd4:    return x ^ z;
            3'd5:    return ~(x ^ z);
            3'd6:    return ~x;
            default: return x;
        endcase
    endfunction

    // Drives one cycle of stimulus and updates the reference model; no checking here.
    task automatic step(input bit v, input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                        input bit sel, input bit clr, input bit rdy);
        logic [7:0] r;
        bit         acc_ok;
        bit         xfer;
        @(negedge clk);
        bus.in_valid  = v;
        bus.op        = o;
        bus.a         = av;
        bus.b         = bv;
        bus.acc_sel   = sel;
        bus.acc_clr   = clr;
        bus.out_ready = rdy;
        #1;
        xfer   = m_valid && rdy;
        acc_ok = v && (!m_valid || rdy);
        if (xfer && sb.size() > 0) void'(sb.pop_front());
        if (acc_ok) begin
            r = model(o, av, sel ? m_acc : bv);
            sb.push_back({r, ~|r, ^r});
            m_acc   = r;
            m_count = m_count + 16'd1;
            m_valid = 1'b1;
        end else if (xfer) begin
            m_valid = 1'b0;
        end
        if (clr) m_acc = 8'h00;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.acc_clr  = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        m_acc   = 8'h00;
        m_valid = 1'b0;
        m_count = 16'd0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.y !== 8'h00) begin errors++; $display("FAIL reset_y got %h exp 00", bus.y); end
        checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b exp 1", bus.zero); end
        checks++; if (bus.parity !== 1'b0) begin errors++; $display("FAIL reset_parity got %b exp 0", bus.parity); end
        checks++; if (bus.op_count !== 16'd0) begin errors++; $display("FAIL reset_op_count got %0d exp 0", bus.op_count); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    endtask

    task automatic test_ops();
        logic [7:0] exp_y [8] = '{8'h30, 8'hFC, 8'hCF, 8'h03, 8'hCC, 8'h33, 8'h0F, 8'hF0};
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'(i), 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b1);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.y !== exp_y[i] || {bus.y, bus.zero, bus.parity} !== sb[0]) begin
                errors++;
                $display("FAIL ops_op%0d got v=%b y=%h exp v=1 y=%h", i, bus.out_valid, bus.y, exp_y[i]);
            end
        end
        checks++; if (bus.op_count !== 16'd8) begin errors++; $display("FAIL ops_count got %0d exp 8", bus.op_count); end
        step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [15:0] cnt0;
        step(1'b1, 3'd0, 8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0);
        cnt0 = bus.op_count;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'd1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
            checks++;
            if (bus.y !== 8'h0F || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.op_count !== cnt0) begin
                errors++;
                $display("FAIL bp_hold%0d got y=%h v=%b rdy=%b cnt=%0d exp y=0f v=1 rdy=0 cnt=%0d",
                         i, bus.y, bus.out_valid, bus.in_ready, bus.op_count, cnt0);
            end
        end
        step(1'b1, 3'd1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.y !== 8'h33 || {bus.y, bus.zero, bus.parity} !== sb[0] || bus.op_count !== cnt0 + 16'd1) begin
            errors++;
            $display("FAIL bp_release got y=%h cnt=%0d exp y=33 cnt=%0d", bus.y, bus.op_count, cnt0 + 16'd1);
        end
        step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_accumulate();
        logic [7:0] av  [4] = '{8'h01, 8'h02, 8'h80, 8'h83};
        logic [2:0] ov  [4] = '{3'd1, 3'd1, 3'd1, 3'd4};
        logic [7:0] exp_y [4] = '{8'h01, 8'h03, 8'h83, 8'h00};
        step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, ov[i], av[i], 8'hAA, 1'b1, 1'b0, 1'b1);
            checks++;
            if (bus.y !== exp_y[i] || {bus.y, bus.zero, bus.parity} !== sb[0]) begin
                errors++;
                $display("FAIL acc_beat%0d got %h exp %h", i, {bus.y, bus.zero, bus.parity}, sb[0]);
            end
        end
        checks++;
        if (bus.zero !== 1'b1 || bus.parity !== 1'b0) begin
            errors++;
            $display("FAIL acc_flags got zero=%b parity=%b exp zero=1 parity=0", bus.zero, bus.parity);
        end
        // Clear on the same edge as a sel beat: beat sees old acc, acc ends at zero.
        step(1'b1, 3'd7, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3'd4, 8'h0F, 8'h00, 1'b1, 1'b1, 1'b1);
        checks++;
        if (bus.y !== 8'hAA || bus.parity !== 1'b0) begin
            errors++;
            $display("FAIL acc_clr_same_edge got y=%h exp aa", bus.y);
        end
        step(1'b1, 3'd1, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1);
        checks++;
        if (bus.y !== 8'h00 || bus.zero !== 1'b1) begin
            errors++;
            $display("FAIL acc_after_clr got y=%h zero=%b exp y=00 zero=1", bus.y, bus.zero);
        end
        step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
            checks++;
            if (bus.out_valid !== 1'b1 || sb.size() != 1 || {bus.y, bus.zero, bus.parity} !== sb[0]) begin
                errors++;
                $display("FAIL b2b_beat%0d got v=%b res=%h exp v=1 res=%h", i, bus.out_valid,
                         {bus.y, bus.zero, bus.parity}, sb[0]);
            end
        end
        step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0 || sb.size() != 0 || bus.op_count !== m_count) begin
            errors++;
            $display("FAIL b2b_drain got v=%b cnt=%0d exp v=0 cnt=%0d", bus.out_valid, bus.op_count, m_count);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 3'd7, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.y !== 8'h5A) begin
            errors++;
            $display("FAIL rmid_setup got v=%b y=%h exp v=1 y=5a", bus.out_valid, bus.y);
        end
        apply_reset();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.y !== 8'h00 || bus.zero !== 1'b1 || bus.op_count !== 16'd0) begin
            errors++;
            $display("FAIL rmid_state got v=%b y=%h z=%b cnt=%0d exp v=0 y=00 z=1 cnt=0",
                     bus.out_valid, bus.y, bus.zero, bus.op_count);
        end
        step(1'b1, 3'd1, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1);
        checks++;
        if (bus.y !== 8'h00 || {bus.y, bus.zero, bus.parity} !== sb[0]) begin
            errors++;
            $display("FAIL rmid_acc got y=%h exp 00", bus.y);
        end
        step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            bus4.in_valid = 1'b1;
            bus4.op       = 3'(i);
            bus4.a        = 8'(i);
            @(posedge clk);
            #1;
            if (i == 15) begin
                checks++;
                if (bus4.op_count !== 4'd0) begin errors++; $display("FAIL wrap_16 got %0d exp 0", bus4.op_count); end
            end
        end
        @(negedge clk);
        bus4.in_valid = 1'b0;
        checks++;
        if (bus4.op_count !== 4'd1) begin errors++; $display("FAIL wrap_17 got %0d exp 1", bus4.op_count); end
    endtask

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.op         = 3'd0;
        bus.a          = 8'h00;
        bus.b          = 8'h00;
        bus.acc_sel    = 1'b0;
        bus.acc_clr    = 1'b0;
        bus.out_ready  = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.op        = 3'd0;
        bus4.a         = 8'h00;
        bus4.b         = 8'h00;
        bus4.acc_sel   = 1'b0;
        bus4.acc_clr   = 1'b0;
        bus4.out_ready = 1'b1;
        m_acc   = 8'h00;
        m_valid = 1'b0;
        m_count = 16'd0;
        repeat (2) @(posedge clk);

        test_reset();
        test_ops();
        test_backpressure();
        test_accumulate();
        test_back_to_back();
        test_reset_mid();
        test_wrap();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/logic_alu.md
LOGIC_ALU -- requirements
Module: logic_alu

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits (legal 1..64).
REQ-002 Parameter: CNT_W, 16, width of completed-operation counter.
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  operand/op beat offered.
REQ-006 Port: in_ready  output  1  block accepts beat this cycle.
REQ-007 Port: op  input  3  opcode: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT_A, 7 PASS_A.
REQ-008 Port: a, b  input  WIDTH each  operands.
REQ-009 Port: acc_sel  input  1  1 = use accumulator in place of b.
REQ-010 Port: acc_clr  input  1  clear accumulator to zero.
REQ-011 Port: out_valid  output  1  result register holds unconsumed result.
REQ-012 Port: out_ready  input  1  downstream accepts result.
REQ-013 Port: y  output  WIDTH  result.
REQ-014 Port: zero  output  1  y == 0.
REQ-015 Port: parity  output  1  XOR-reduction of y.
REQ-016 Port: op_count  output  CNT_W  number of accepted beats since reset.

Function
REQ-017 Accept = in_valid & in_ready; output transfer = out_valid & out_ready.
REQ-018 in_ready = !out_valid | out_ready (combinational; one-entry pipeline, full throughput).
REQ-019 Latency exactly 1 cycle: beat accepted at edge N appears on y with out_valid=1 after edge N.
REQ-020 Operand B = acc_sel ? acc : b; result = bitwise op on A, B per REQ-007, full WIDTH, no carries.
REQ-021 y, zero, parity registered together at accept; held stable while out_valid & !out_ready.
REQ-022 out_valid set on accept; cleared on transfer without simultaneous accept; stays 1 on simultaneous transfer+accept (new result replaces old).
REQ-023 Accumulator acc (WIDTH, internal) loads the computed result on every accept.
REQ-024 acc_clr asserted: acc <= 0 at that edge, overriding a simultaneous accept's load; the accepted beat's y still uses pre-clear acc if acc_sel=1.
REQ-025 op_count increments on each accept; wraps from 2^CNT_W-1 to 0 silently.
REQ-026 in_valid deasserted: no state change except acc_clr and output transfer.
REQ-027 Inputs a, b, op, acc_sel ignored when no accept occurs.

Reset
REQ-028 rst at an edge: out_valid=0, y=0, zero=1, parity=0, acc=0, op_count=0; overrides all other activity that edge.
REQ-029 Reset mid-operation discards any pending result; no transfer reported for it.
REQ-030 in_ready=1 in the first cycle after reset deasserts.

Structure
REQ-031 Shared package holds the opcode enumeration (3-bit) and default WIDTH constant.
REQ-032 One sub-module natural: logic_op_core, purely combinational (op, a, b) -> result, instantiated once.
REQ-033 All sequential state (result reg, flags, acc, counter) in logic_alu only.

Verification
REQ-034 WIDTH=8, out_ready=1: a=8'hF0, b=8'h3C through ops 0..7 -> y=30,FC,CF,03,CC,33,0F,F0 one cycle after each accept; op_count=8.
REQ-035 Backpressure: accept a=8'hFF,b=8'h0F,op=AND, out_ready=0 for 3 cycles -> y=0F held, in_ready=0, second offered beat not accepted until out_ready=1.
REQ-036 Accumulate: acc_clr, then accept a=8'h01,acc_sel=1,op=OR; a=8'h02; a=8'h80 -> y=01,03,83; then op=XOR a=8'h83 -> y=00, zero=1, parity=0.
REQ-037 Simultaneous transfer+accept every cycle for 10 beats -> out_valid never drops, no beat lost or duplicated.
REQ-038 rst asserted while out_valid=1 and acc=8'h5A -> next cycle out_valid=0, y=0, zero=1, acc=0, op_count=0.
REQ-039 CNT_W=4: 17 accepts -> op_count=1 (wrap).
